// File: rtl/io_bus_master.sv
// io_bus_master: initiator for the IO address space. It turns single pipeline
// load/store requests into word-wide IO bus transactions. Sub-word loads are
// lane-extracted and extended here. Sub-word stores become read-modify-write,
// because responders only accept full-word writes.
module io_bus_master #(
  parameter int RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] io_addr,
  output logic        io_en,
  output logic        io_we,
  output logic [31:0] io_din,
  input  logic [31:0] io_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;
  logic [3:0]  wait_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [15:0] wdata_q;

  logic accept;
  logic req_bad;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Flag illegal sizes and misaligned half/word accesses at acceptance.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
      SZ_BYTE: req_bad = 1'b0;
      default: req_bad = 1'b1;
    endcase
  end

  // Pick the addressed lane(s) out of a bus word and sign/zero extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{~uns & b[7]}}, b};
      SZ_HALF: r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay store data onto the addressed lane(s), keeping the other lanes.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic [15:0] wdata);
    logic [31:0] r;
    r = word;
    if (size == SZ_BYTE)
      r[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (lane[1])
      r[31:16] = wdata;
    else
      r[15:0] = wdata;
    return r;
  endfunction

  // Capture the request attributes needed after acceptance.
  // NOTE: pure datapath capture registers are not reset; they are only
  // consumed in states reached after a fresh acceptance loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lane_q  <= req_addr[1:0];
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      we_q    <= req_we;
      wdata_q <= req_wdata[15:0];
    end
  end

  // Transaction FSM with all bus and response outputs registered.
  // NOTE: non-blocking assignments throughout, so every output reflects the
  // state decided at the previous edge and no ordering races exist.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_q    <= '0;
      io_addr   <= '0;
      io_en     <= 1'b0;
      io_we     <= 1'b0;
      io_din    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_bad) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && (req_size == SZ_WORD)) begin
              state   <= WR;
              io_en   <= 1'b1;
              io_we   <= 1'b1;
              io_addr <= {req_addr[31:2], 2'b00};
              io_din  <= req_wdata;
            end else begin
              state   <= RD;
              io_en   <= 1'b1;
              io_addr <= {req_addr[31:2], 2'b00};
              wait_q  <= 4'(RD_WAIT);
            end
          end
        end
        RD: begin
          if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else if (we_q) begin
            // Keep io_en and io_addr; the write goes to the same word.
            state  <= WR;
            io_we  <= 1'b1;
            io_din <= store_merge(io_dout, lane_q, size_q, wdata_q);
          end else begin
            state     <= RSP;
            io_en     <= 1'b0;
            io_addr   <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_extend(io_dout, lane_q, size_q, uns_q);
          end
        end
        WR: begin
          state     <= RSP;
          io_en     <= 1'b0;
          io_we     <= 1'b0;
          io_addr   <= '0;
          io_din    <= '0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        RSP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: one instance with RD_WAIT=0 and one with
// RD_WAIT=2, both fed by a simple responder returning the word in rword.
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] wdata;
  logic [31:0] rword;

  logic        r0_valid, r0_ready, rsp0_valid, rsp0_err, io0_en, io0_we;
  logic [31:0] rsp0_rdata, io0_addr, io0_din;
  logic        r2_valid, r2_ready, rsp2_valid, rsp2_err, io2_en, io2_we;
  logic [31:0] rsp2_rdata, io2_addr, io2_din;

  int errors = 0;
  int checks = 0;
  int we_cnt0 = 0;
  int en_cnt0 = 0;
  int rsp_cnt0 = 0;
  int we_base, en_base, rsp_base;

  always #5 clk = ~clk;

  io_bus_master #(.RD_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(r0_valid), .req_ready(r0_ready), .req_addr(addr), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_wdata(wdata),
    .rsp_valid(rsp0_valid), .rsp_rdata(rsp0_rdata), .rsp_err(rsp0_err),
    .io_addr(io0_addr), .io_en(io0_en), .io_we(io0_we), .io_din(io0_din),
    .io_dout(rword)
  );

  io_bus_master #(.RD_WAIT(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(r2_valid), .req_ready(r2_ready), .req_addr(addr), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_wdata(wdata),
    .rsp_valid(rsp2_valid), .rsp_rdata(rsp2_rdata), .rsp_err(rsp2_err),
    .io_addr(io2_addr), .io_en(io2_en), .io_we(io2_we), .io_din(io2_din),
    .io_dout(rword)
  );

  // Strobe counters for the RD_WAIT=0 instance.
  always @(posedge clk) begin
    if (io0_we)     we_cnt0++;
    if (io0_en)     en_cnt0++;
    if (rsp0_valid) rsp_cnt0++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request to the RD_WAIT=0 instance in cycle 0; returns in cycle 1.
  task automatic issue0(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; size = s; uns = u; addr = a; wdata = d;
    r0_valid = 1'b1;
    step();
    r0_valid = 1'b0;
  endtask

  task automatic snap();
    we_base = we_cnt0; en_base = en_cnt0; rsp_base = rsp_cnt0;
  endtask

  // Load through the RD_WAIT=0 instance and check the response in cycle 2.
  task automatic load0(input string tag, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] exp);
    issue0(1'b0, s, u, a, 32'h0);
    step();
    check({tag, "_valid"}, 32'(rsp0_valid), 32'd1);
    check({tag, "_rdata"}, rsp0_rdata, exp);
    step();
  endtask

  initial begin
    reset = 1'b1;
    r0_valid = 1'b0; r2_valid = 1'b0;
    addr = '0; we = 1'b0; size = 2'b10; uns = 1'b0; wdata = '0; rword = '0;
    repeat (3) step();

    // Reset state
    check("rst_ready0", 32'(r0_ready), 32'd0);
    check("rst_ready2", 32'(r2_ready), 32'd0);
    check("rst_en", 32'(io0_en), 32'd0);
    check("rst_rsp", 32'(rsp0_valid), 32'd0);
    check("rst_addr", io0_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(r0_ready), 32'd1);

    // Word load, RD_WAIT=0
    rword = 32'h12345678;
    issue0(1'b0, 2'b10, 1'b0, 32'h80000010, 32'h0);
    check("wl_c1_en", 32'(io0_en), 32'd1);
    check("wl_c1_addr", io0_addr, 32'h80000010);
    check("wl_c1_we", 32'(io0_we), 32'd0);
    check("wl_c1_ready", 32'(r0_ready), 32'd0);
    step();
    check("wl_c2_en", 32'(io0_en), 32'd0);
    check("wl_c2_valid", 32'(rsp0_valid), 32'd1);
    check("wl_c2_rdata", rsp0_rdata, 32'h12345678);
    check("wl_c2_err", 32'(rsp0_err), 32'd0);
    step();
    check("wl_c3_valid", 32'(rsp0_valid), 32'd0);
    check("wl_c3_ready", 32'(r0_ready), 32'd1);
    check("wl_c3_hold", rsp0_rdata, 32'h12345678);

    // Extension cases on word 0x80AA55CC
    rword = 32'h80AA55CC;
    load0("sb13", 2'b00, 1'b0, 32'h80000013, 32'hFFFFFF80);
    load0("uh12", 2'b01, 1'b1, 32'h80000012, 32'h000080AA);
    load0("sb10", 2'b00, 1'b0, 32'h80000010, 32'hFFFFFFCC);
    load0("ub13", 2'b00, 1'b1, 32'h80000013, 32'h00000080);
    load0("sh10", 2'b01, 1'b0, 32'h80000010, 32'h000055CC);
    load0("sh12", 2'b01, 1'b0, 32'h80000012, 32'hFFFF80AA);

    // Errors: no strobes, rsp_err in cycle 1 with zero data
    snap();
    issue0(1'b0, 2'b01, 1'b0, 32'h80000011, 32'h0);
    check("eh_valid", 32'(rsp0_valid), 32'd1);
    check("eh_err", 32'(rsp0_err), 32'd1);
    check("eh_rdata", rsp0_rdata, 32'h0);
    step();
    issue0(1'b0, 2'b11, 1'b0, 32'h80000010, 32'h0);
    check("es_err", 32'(rsp0_err), 32'd1);
    check("es_rdata", rsp0_rdata, 32'h0);
    step();
    issue0(1'b1, 2'b10, 1'b0, 32'h80000012, 32'hDEADBEEF);
    check("ew_err", 32'(rsp0_err), 32'd1);
    step();
    check("err_no_en", 32'(en_cnt0 - en_base), 32'd0);
    check("err_no_we", 32'(we_cnt0 - we_base), 32'd0);
    check("err_rsp_cnt", 32'(rsp_cnt0 - rsp_base), 32'd3);

    // RMW byte store
    rword = 32'h11223344;
    snap();
    issue0(1'b1, 2'b00, 1'b0, 32'h80000019, 32'h000000EE);
    check("sb_c1_en", 32'(io0_en), 32'd1);
    check("sb_c1_we", 32'(io0_we), 32'd0);
    check("sb_c1_addr", io0_addr, 32'h80000018);
    step();
    check("sb_c2_we", 32'(io0_we), 32'd1);
    check("sb_c2_addr", io0_addr, 32'h80000018);
    check("sb_c2_din", io0_din, 32'h1122EE44);
    check("sb_c2_valid", 32'(rsp0_valid), 32'd0);
    step();
    check("sb_c3_valid", 32'(rsp0_valid), 32'd1);
    check("sb_c3_we", 32'(io0_we), 32'd0);
    check("sb_c3_din", io0_din, 32'h0);
    check("sb_c3_rdata", rsp0_rdata, 32'h0);
    step();
    check("sb_we_once", 32'(we_cnt0 - we_base), 32'd1);

    // RMW half store to upper lane
    issue0(1'b1, 2'b01, 1'b0, 32'h8000001A, 32'h1234BEEF);
    step();
    check("sh_din", io0_din, 32'hBEEF3344);
    step();
    step();

    // Word store
    snap();
    issue0(1'b1, 2'b10, 1'b0, 32'h80000020, 32'hCAFEF00D);
    check("ws_c1_we", 32'(io0_we), 32'd1);
    check("ws_c1_din", io0_din, 32'hCAFEF00D);
    check("ws_c1_addr", io0_addr, 32'h80000020);
    step();
    check("ws_c2_valid", 32'(rsp0_valid), 32'd1);
    check("ws_c2_we", 32'(io0_we), 32'd0);
    step();
    check("ws_we_once", 32'(we_cnt0 - we_base), 32'd1);

    // Slow responder, RD_WAIT=2, second request held valid
    rword = 32'h0BADF00D;
    @(negedge clk);
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h80000040;
    r2_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("slow_c%0d_en", c), 32'(io2_en), 32'd1);
      check($sformatf("slow_c%0d_ready", c), 32'(r2_ready), 32'd0);
      check($sformatf("slow_c%0d_valid", c), 32'(rsp2_valid), 32'd0);
    end
    step();
    check("slow_c4_valid", 32'(rsp2_valid), 32'd1);
    check("slow_c4_rdata", rsp2_rdata, 32'h0BADF00D);
    check("slow_c4_en", 32'(io2_en), 32'd0);
    check("slow_c4_ready", 32'(r2_ready), 32'd0);
    step();
    check("slow_c5_ready", 32'(r2_ready), 32'd1);
    check("slow_c5_en", 32'(io2_en), 32'd0);
    step();
    r2_valid = 1'b0;
    check("slow_c6_en", 32'(io2_en), 32'd1);
    check("slow_c6_ready", 32'(r2_ready), 32'd0);
    repeat (3) step();
    check("slow_c9_valid", 32'(rsp2_valid), 32'd1);
    step();

    // Reset during cycle 1 of a sub-word store
    rword = 32'h55667788;
    snap();
    issue0(1'b1, 2'b00, 1'b0, 32'h80000031, 32'h000000AB);
    check("rm_c1_en", 32'(io0_en), 32'd1);
    reset = 1'b1;
    step();
    check("rm_we", 32'(io0_we), 32'd0);
    check("rm_en", 32'(io0_en), 32'd0);
    check("rm_addr", io0_addr, 32'h0);
    check("rm_din", io0_din, 32'h0);
    check("rm_ready", 32'(r0_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rm_ready_after", 32'(r0_ready), 32'd1);
    repeat (4) step();
    check("rm_no_we", 32'(we_cnt0 - we_base), 32'd0);
    check("rm_no_rsp", 32'(rsp_cnt0 - rsp_base), 32'd0);
    check("rm_rdata", rsp0_rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
